stopwatch_timebase: RTL and testbench
=====================================

Name: stopwatch_timebase

Overview:
- Upstream stage of the stopwatch display path: it produces the 6-bit seconds value that the BCD split/segment stage consumes.
- Divides clk_50 down to a 1 Hz tick and debounces the two pushbuttons.
- Runs an IDLE/RUN/PAUSE control FSM and holds the 0..MAX_COUNT seconds counter, with a wrap pulse for a later minutes stage.

Parameters:
- CLK_HZ, 50000000: input clock frequency in Hz.
- TICK_HZ, 1: count rate in Hz. DIV = CLK_HZ/TICK_HZ, and DIV must be at least 2.
- DEB_CYCLES, 1000000: number of consecutive stable samples required to accept a button level (20 ms at 50 MHz). Must be at least 1.
- MAX_COUNT, 59: terminal count before wrap. Must be at most 63.

Ports:
- clk_50  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key_ss  in  1  raw start/stop pushbutton, active-low, asynchronous to clk_50
- key_clr  in  1  raw clear pushbutton, active-low, asynchronous to clk_50
- sec  out  6  current count, 0..MAX_COUNT; feeds the display stage
- running  out  1  high while the FSM is in RUN
- sec_tick  out  1  one-cycle pulse, coincident with each sec update
- min_tick  out  1  one-cycle pulse, coincident with the sec wrap from MAX_COUNT to 0

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; sec, prescaler, debounce counters, running, sec_tick and min_tick all 0.
  - Synchronizer flops and debounced levels set to 1 (released).
- Input conditioning, per key:
  - 2-flop synchronizer feeds a debouncer.
  - The debounced level takes the new synchronized value after that value differs from it for DEB_CYCLES consecutive cycles. Any bounce back resets the debounce counter.
  - Press event = debounced level going 1 to 0, a single-cycle internal pulse. Release produces no event.
  - Holding a key produces exactly one event.
- Latency: raw key low and held stable -> FSM state / sec reflect the press exactly DEB_CYCLES+3 clk_50 cycles later.
- FSM:
  - IDLE + ss event -> RUN.
  - RUN + ss event -> PAUSE.
  - PAUSE + ss event -> RUN.
  - Any state + clr event -> IDLE.
  - Simultaneous ss and clr events: clr wins and the result is IDLE.
  - clr in IDLE: no observable change.
- Prescaler:
  - Width is clog2(DIV). Counts 0..DIV-1, advancing only in RUN.
  - Holds its value in PAUSE, so resume keeps the partial second.
  - Forced to 0 in IDLE and on entry to IDLE.
- Tick: generated on the edge where the prescaler is at DIV-1 and the state is RUN.
  - At that edge: prescaler goes to 0, sec goes to sec+1, and sec_tick=1 for the following cycle.
  - If sec==MAX_COUNT, sec goes to 0 and min_tick=1 alongside sec_tick.
- Ordering within a cycle:
  - A tick in the same cycle as an ss event while in RUN is still counted; the state moves to PAUSE afterwards.
  - A tick in the same cycle as a clr event is discarded: sec=0 and no pulses.
- Outputs are registered:
  - running = (state==RUN).
  - First tick after starting from IDLE occurs exactly DIV cycles after the RUN entry edge.
- sec never exceeds MAX_COUNT; no intermediate values are visible on the output.
- Reset mid-RUN: all outputs 0 immediately, without waiting for a clock edge. After rst deasserts, the block waits in IDLE.

Test Plan:
(All scenarios use CLK_HZ=100, TICK_HZ=1, DEB_CYCLES=4, MAX_COUNT=59, so DIV=100.)
- Reset: hold rst=0 while driving the keys randomly -> sec=0, running=0, sec_tick=0, min_tick=0 throughout. After release, nothing changes until a press.
- Start and count:
  - Hold key_ss low for 10 cycles, starting at cycle t -> running rises after exactly 7 cycles (DEB_CYCLES+3).
  - sec_tick first pulses 100 cycles after RUN entry; sec reads 1, then 2 after a further 100 cycles.
  - Exactly one start event despite the long hold.
- Bounce rejection: toggle key_ss every 2 cycles for 20 cycles, then release -> no state change; running stays 0.
- Pause and resume:
  - Pause 30 cycles into second 5 -> sec holds at 5 with no ticks during the pause.
  - Resume -> the next tick arrives 70 cycles after RUN re-entry.
- Wrap: run from IDLE for 60 ticks -> sec sequence 1..59 then 0; min_tick pulses only on the 59->0 tick, together with sec_tick.
- Clear priority:
  - Press key_clr and key_ss together while in RUN at sec=12 -> IDLE with sec=0 and running=0.
  - A following ss press restarts with the first tick a full 100 cycles later.
  - Asserting rst low mid-RUN -> immediate zeroed outputs.

Source files
------------

// File: rtl/stopwatch_timebase.sv
// Stopwatch front end: debounces the two pushbuttons, divides clk_50 to the count rate
// and runs the IDLE/RUN/PAUSE seconds counter with a wrap pulse for the minutes stage.
module stopwatch_timebase #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TICK_HZ    = 1,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int MAX_COUNT  = 59
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       key_ss,
    input  logic       key_clr,
    output logic [5:0] sec,
    output logic       running,
    output logic       sec_tick,
    output logic       min_tick
);

    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [5:0]       SEC_LAST = 6'(MAX_COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Bit 0 is start/stop, bit 1 is clear; both keys are active-low.
    logic [1:0]       key_raw;
    logic [1:0]       sync1_q, sync2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       press_q, press_d;
    logic [DEB_W-1:0] cnt_q [2];
    logic [DEB_W-1:0] cnt_d [2];

    assign key_raw = {key_clr, key_ss};

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            deb_d[k] = deb_q[k];
            cnt_d[k] = '0;
            if (sync2_q[k] != deb_q[k]) begin
                if (cnt_q[k] == DEB_LAST) begin
                    deb_d[k] = sync2_q[k];
                end else begin
                    cnt_d[k] = cnt_q[k] + DEB_W'(1);
                end
            end
            press_d[k] = deb_q[k] & ~deb_d[k];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            press_q <= '0;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= key_raw;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    state_e           state_q;
    logic [PRE_W-1:0] pre_q;
    logic [5:0]       sec_q;
    logic             running_q, sec_tick_q, min_tick_q;
    logic             ss_ev, clr_ev, tick;

    assign ss_ev  = press_q[0];
    assign clr_ev = press_q[1];
    assign tick   = (state_q == RUN) && (pre_q == PRE_LAST);

    // Clear overrides everything, including a tick or a start/stop press in the same cycle.
    always_ff @(posedge clk_50 or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pre_q      <= '0;
            sec_q      <= '0;
            running_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            min_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= 1'b0;
            min_tick_q <= 1'b0;
            if (clr_ev) begin
                state_q   <= IDLE;
                pre_q     <= '0;
                sec_q     <= '0;
                running_q <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        pre_q <= '0;
                        if (ss_ev) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            pre_q      <= '0;
                            sec_tick_q <= 1'b1;
                            if (sec_q == SEC_LAST) begin
                                sec_q      <= '0;
                                min_tick_q <= 1'b1;
                            end else begin
                                sec_q <= sec_q + 6'd1;
                            end
                        end else begin
                            pre_q <= pre_q + PRE_W'(1);
                        end
                        // A tick coinciding with the stop press is still counted above.
                        if (ss_ev) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end
                    end
                    PAUSE: begin
                        if (ss_ev) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        pre_q     <= '0;
                        sec_q     <= '0;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign sec      = sec_q;
    assign running  = running_q;
    assign sec_tick = sec_tick_q;
    assign min_tick = min_tick_q;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Directed bench for stopwatch_timebase at CLK_HZ=100, DEB_CYCLES=4 (DIV=100, press latency 7).
module tb_stopwatch_timebase;

    logic       clk_50 = 1'b0;
    logic       rst = 1'b0;
    logic       key_ss = 1'b1;
    logic       key_clr = 1'b1;
    logic [5:0] sec;
    logic       running, sec_tick, min_tick;

    int n_total = 0;
    int n_pass  = 0;
    int stray_min = 0;

    stopwatch_timebase #(
        .CLK_HZ    (100),
        .TICK_HZ   (1),
        .DEB_CYCLES(4),
        .MAX_COUNT (59)
    ) dut (
        .clk_50  (clk_50),
        .rst     (rst),
        .key_ss  (key_ss),
        .key_clr (key_clr),
        .sec     (sec),
        .running (running),
        .sec_tick(sec_tick),
        .min_tick(min_tick)
    );

    always #5 clk_50 = ~clk_50;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one clock and settle just past the edge; inputs and samples happen here.
    task automatic step();
        @(posedge clk_50);
        #1;
    endtask

    // Cycles until the next sec_tick, or -1 if none arrives within the bound.
    task automatic wait_tick(output int n);
        n = -1;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (min_tick && !sec_tick) stray_min++;
            if (sec_tick) begin
                n = i;
                break;
            end
        end
    endtask

    int n;

    initial begin
        // Reset held with keys thrashing: everything stays zero.
        for (int i = 0; i < 12; i++) begin
            key_ss  = 1'($urandom_range(0, 1));
            key_clr = 1'($urandom_range(0, 1));
            step();
            check("rst_hold_outs", {sec, running, sec_tick, min_tick}, 0);
        end
        key_ss  = 1'b1;
        key_clr = 1'b1;
        step();
        rst = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("post_rst_running", running, 0);
        check("post_rst_sec", sec, 0);

        // Bounce: never low for four consecutive samples, so no press is accepted.
        for (int i = 0; i < 20; i++) begin
            key_ss = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        key_ss = 1'b1;
        for (int i = 0; i < 12; i++) step();
        check("bounce_running", running, 0);
        check("bounce_sec", sec, 0);

        // Start: running rises exactly 7 cycles after the key drops.
        key_ss = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) check("start_lat_6", running, 0);
            if (i == 7) check("start_lat_7", running, 1);
        end
        key_ss = 1'b1;
        // RUN entry was 7 cycles in, we are at 10, so the tick is 97 away.
        wait_tick(n);
        check("first_tick_lat", n, 97);
        check("first_tick_sec", sec, 1);
        check("first_tick_min", min_tick, 0);
        wait_tick(n);
        check("second_tick_lat", n, 100);
        check("second_tick_sec", sec, 2);
        check("one_start_event", running, 1);

        for (int s = 3; s <= 5; s++) begin
            wait_tick(n);
            check("count_lat", n, 100);
            check("count_sec", sec, s);
        end

        // Pause lands 30 cycles into second 5.
        for (int i = 0; i < 23; i++) step();
        key_ss = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) check("pause_lat_6", running, 1);
            if (i == 7) check("pause_lat_7", running, 0);
        end
        key_ss = 1'b1;
        n = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (sec_tick) n++;
        end
        check("pause_no_ticks", n, 0);
        check("pause_sec_hold", sec, 5);

        // Resume keeps the partial second: 70 cycles remain.
        key_ss = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("resume_running", running, 1);
        key_ss = 1'b1;
        wait_tick(n);
        check("resume_tick_lat", n, 70);
        check("resume_sec", sec, 6);

        for (int s = 7; s <= 12; s++) wait_tick(n);
        check("pre_clr_sec", sec, 12);

        // Clear and start/stop together: clear wins.
        for (int i = 0; i < 10; i++) step();
        key_ss  = 1'b0;
        key_clr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 6) check("clr_lat_6_sec", sec, 12);
            if (i == 7) check("clr_lat_7_out", {sec, running, sec_tick, min_tick}, 0);
        end
        key_ss  = 1'b1;
        key_clr = 1'b1;
        for (int i = 0; i < 15; i++) step();
        check("clr_idle_running", running, 0);
        check("clr_idle_sec", sec, 0);

        // Restart from IDLE and run a full minute.
        key_ss = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("restart_running", running, 1);
        key_ss = 1'b1;
        stray_min = 0;
        for (int k = 1; k <= 60; k++) begin
            wait_tick(n);
            check("wrap_lat", n, 100);
            check("wrap_sec", sec, k % 60);
            check("wrap_min", min_tick, (k == 60) ? 1 : 0);
        end
        check("stray_min", stray_min, 0);

        // Reset mid-RUN while sec_tick is high: outputs clear without a clock edge.
        wait_tick(n);
        check("pre_rst_sec", sec, 1);
        rst = 1'b0;
        #1;
        check("async_rst_outs", {sec, running, sec_tick, min_tick}, 0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 150; i++) step();
        check("post_rst2_running", running, 0);
        check("post_rst2_sec", sec, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
